// File: rtl/evict_push.sv
// ---------------------------------------------------------------------------
// evict_push
//
// Upstream feeder for the eviction write path. Victim lines arrive from the
// cache tag/replacement logic over a valid/ready handshake. A dirty victim is
// turned into a line address plus a data word. Both are pushed in the same
// cycle into the AW FIFO and the W FIFO that the eviction AW/W issuer drains.
// A clean victim is dropped.
//
// An in-flight count tracks lines that have been pushed but not yet
// completed. The cache uses it to hold off fills that might overtake a
// pending writeback.
//
// Ports
//   clk, rst_n        single clock; synchronous, active-low reset
//   victim_*          victim handshake and payload (tag, index, dirty, data)
//   awfifo_afull_i    AW FIFO almost full (needs at least one entry of slack)
//   awfifo_wren_o     AW FIFO push strobe
//   awfifo_wdata_o    AW FIFO push data: the line address
//   wfifo_afull_i     W FIFO almost full (needs at least one entry of slack)
//   wfifo_wren_o      W FIFO push strobe
//   wfifo_wdata_o     W FIFO push data: the line data
//   evict_done_i      one-cycle pulse per completed writeback
//   inflight_o        count of lines pushed but not yet completed
//   evict_busy_o      a line is pending, or the in-flight count is nonzero
//
// Optional build macro
//   EVICT_PUSH_STAT_EN  adds three 32-bit saturating counters:
//                       stat_dirty_o, stat_clean_o and stat_stall_o.
//
// TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH must not exceed ADDR_WIDTH.
// ---------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module evict_push #(
  parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 10,
  parameter int OFFSET_WIDTH = 6,
  parameter int INFLIGHT_LG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    victim_valid_i,
  output logic                    victim_ready_o,
  input  logic [TAG_WIDTH-1:0]    victim_tag_i,
  input  logic [INDEX_WIDTH-1:0]  victim_index_i,
  input  logic                    victim_dirty_i,
  input  logic [DATA_WIDTH-1:0]   victim_data_i,
  input  logic                    awfifo_afull_i,
  output logic                    awfifo_wren_o,
  output logic [ADDR_WIDTH-1:0]   awfifo_wdata_o,
  input  logic                    wfifo_afull_i,
  output logic                    wfifo_wren_o,
  output logic [DATA_WIDTH-1:0]   wfifo_wdata_o,
  input  logic                    evict_done_i,
  output logic [INFLIGHT_LG2-1:0] inflight_o,
  output logic                    evict_busy_o
`ifdef EVICT_PUSH_STAT_EN
  ,
  output logic [31:0]             stat_dirty_o,
  output logic [31:0]             stat_clean_o,
  output logic [31:0]             stat_stall_o
`endif
);

  localparam int LINE_ADDR_W = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
  localparam logic [INFLIGHT_LG2-1:0] INFLIGHT_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PUSH = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [INFLIGHT_LG2-1:0] inflight_q;

  logic accept;
  logic capture;
  logic push;
  logic done_eff;

  // Line address: {tag, index, zero offset}. The upper bits are zero-extended.
  always_comb begin
    addr_next = '0;
    addr_next[LINE_ADDR_W-1:0] = {victim_tag_i, victim_index_i,
                                  {OFFSET_WIDTH{1'b0}}};
  end

  // Handshake and push decode. Everything here is combinational from the
  // state and the afull/inflight inputs. Gating with rst_n keeps ready and
  // the strobes low while reset is held, including a reset in mid-push.
  // NOTE: every output of an always_comb gets a default assignment first.
  // Without the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_d        = state_q;
    victim_ready_o = 1'b0;
    push           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        victim_ready_o = rst_n;
        if (victim_valid_i && victim_dirty_i && rst_n) state_d = S_PUSH;
      end
      S_PUSH: begin
        push = rst_n && !awfifo_afull_i && !wfifo_afull_i &&
               (inflight_q != INFLIGHT_MAX);
        if (push) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept   = victim_valid_i && victim_ready_o;
  assign capture  = accept && victim_dirty_i;
  // A completion that arrives while the count is zero is spurious. It is
  // ignored so that the counter cannot underflow.
  assign done_eff = evict_done_i && (inflight_q != '0);

  // NOTE: sequential state is assigned with non-blocking (<=) only. Each
  // flop then samples the pre-edge value of every other flop, with no
  // dependence on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q <= addr_next;
        data_q <= victim_data_i;
      end
      // A push and a completion in the same cycle cancel out.
      unique case ({push, done_eff})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Both FIFOs are pushed on one shared strobe, so entry k in the AW FIFO
  // always pairs with entry k in the W FIFO.
  assign awfifo_wren_o  = push;
  assign wfifo_wren_o   = push;
  assign awfifo_wdata_o = addr_q;
  assign wfifo_wdata_o  = data_q;
  assign inflight_o     = inflight_q;
  assign evict_busy_o   = (state_q != S_IDLE) || (inflight_q != '0);

`ifdef EVICT_PUSH_STAT_EN
  logic [31:0] stat_dirty_q, stat_clean_q, stat_stall_q;
  logic        stall;

  assign stall = (state_q == S_PUSH) && !push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_dirty_q <= '0;
      stat_clean_q <= '0;
      stat_stall_q <= '0;
    end else begin
      // All three counters saturate at all-ones instead of wrapping.
      if (push && (stat_dirty_q != '1))
        stat_dirty_q <= stat_dirty_q + 32'd1;
      if (accept && !victim_dirty_i && (stat_clean_q != '1))
        stat_clean_q <= stat_clean_q + 32'd1;
      if (stall && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_dirty_o = stat_dirty_q;
  assign stat_clean_o = stat_clean_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_evict_push.sv
// ---------------------------------------------------------------------------
// tb_evict_push
//
// Self-checking bench for evict_push. The reference model is a pending-line
// flag, a pending address/data pair, an integer in-flight count and
// statistics tallies. All of it is updated from the handshake rules on each
// clock edge.
//
// Sequence: directed scenarios first, then a randomized stream. Every
// comparison goes through check().
// ---------------------------------------------------------------------------
module tb_evict_push;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TW  = 18;
  localparam int IW  = 8;
  localparam int OW  = 6;
  localparam int ILG = 4;
  localparam int MAX_INFLIGHT = (1 << ILG) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           victim_valid;
  logic           victim_ready;
  logic [TW-1:0]  victim_tag;
  logic [IW-1:0]  victim_index;
  logic           victim_dirty;
  logic [DW-1:0]  victim_data;
  logic           awfifo_afull;
  logic           awfifo_wren;
  logic [AW-1:0]  awfifo_wdata;
  logic           wfifo_afull;
  logic           wfifo_wren;
  logic [DW-1:0]  wfifo_wdata;
  logic           evict_done;
  logic [ILG-1:0] inflight;
  logic           evict_busy;
`ifdef EVICT_PUSH_STAT_EN
  logic [31:0]    stat_dirty, stat_clean, stat_stall;
`endif

  evict_push #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW),
    .INDEX_WIDTH (IW),
    .OFFSET_WIDTH(OW),
    .INFLIGHT_LG2(ILG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .victim_valid_i(victim_valid),
    .victim_ready_o(victim_ready),
    .victim_tag_i  (victim_tag),
    .victim_index_i(victim_index),
    .victim_dirty_i(victim_dirty),
    .victim_data_i (victim_data),
    .awfifo_afull_i(awfifo_afull),
    .awfifo_wren_o (awfifo_wren),
    .awfifo_wdata_o(awfifo_wdata),
    .wfifo_afull_i (wfifo_afull),
    .wfifo_wren_o  (wfifo_wren),
    .wfifo_wdata_o (wfifo_wdata),
    .evict_done_i  (evict_done),
    .inflight_o    (inflight),
    .evict_busy_o  (evict_busy)
`ifdef EVICT_PUSH_STAT_EN
    ,
    .stat_dirty_o  (stat_dirty),
    .stat_clean_o  (stat_clean),
    .stat_stall_o  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  bit      pending;
  longint  p_addr;
  longint  p_data;
  int      cnt;
  int      m_dirty, m_clean, m_stall;

  function automatic longint line_addr(input longint tag, input longint idx);
    return (tag * (64'd1 << (IW + OW))) + (idx * (64'd1 << OW));
  endfunction

  // Checks the outputs for the current inputs, clocks one edge, then
  // advances the model. Returns at posedge+1, when new inputs may be driven.
  task automatic cycle();
    bit exp_push;
    bit exp_ready;
    #1;
    exp_ready = rst_n && !pending;
    exp_push  = rst_n && pending && !awfifo_afull && !wfifo_afull &&
                (cnt != MAX_INFLIGHT);
    check("ready",    64'(victim_ready), 64'(exp_ready));
    check("aw_wren",  64'(awfifo_wren),  64'(exp_push));
    check("w_wren",   64'(wfifo_wren),   64'(exp_push));
    check("inflight", 64'(inflight),     64'(cnt));
    if (rst_n) check("busy", 64'(evict_busy), 64'(pending || cnt != 0));
    if (exp_push) begin
      check("aw_data", 64'(awfifo_wdata), p_addr);
      check("w_data",  64'(wfifo_wdata),  p_data);
    end
`ifdef EVICT_PUSH_STAT_EN
    check("st_dirty", 64'(stat_dirty), 64'(m_dirty));
    check("st_clean", 64'(stat_clean), 64'(m_clean));
    check("st_stall", 64'(stat_stall), 64'(m_stall));
`endif
    @(posedge clk);
    if (!rst_n) begin
      pending = 0; p_addr = 0; p_data = 0; cnt = 0;
      m_dirty = 0; m_clean = 0; m_stall = 0;
    end else begin
      if (pending && !exp_push) m_stall++;
      cnt = cnt + (exp_push ? 1 : 0) - ((evict_done && cnt > 0) ? 1 : 0);
      if (exp_push) begin pending = 0; m_dirty++; end
      if (victim_valid && exp_ready) begin
        if (victim_dirty) begin
          pending = 1;
          p_addr  = line_addr(longint'(victim_tag), longint'(victim_index));
          p_data  = longint'(victim_data);
        end else m_clean++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    victim_valid = 0; victim_dirty = 0; evict_done = 0;
    awfifo_afull = 0; wfifo_afull = 0;
  endtask

  task automatic offer(input bit dirty);
    victim_valid = 1;
    victim_dirty = dirty;
    victim_tag   = TW'($urandom);
    victim_index = IW'($urandom);
    victim_data  = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    cycle();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    victim_tag = '0; victim_index = '0; victim_data = '0;
    pending = 0; p_addr = 0; p_data = 0; cnt = 0;
    m_dirty = 0; m_clean = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_low", 64'(victim_ready), 64'd0);
    rst_n = 1;
    cycle();  // the first cycle after release checks the reset state

    // Directed dirty victim with the known line address
    victim_valid = 1; victim_dirty = 1;
    victim_tag   = 18'h12345; victim_index = 8'h3A;
    victim_data  = 64'hDEADBEEF_CAFEF00D;
    cycle();
    idle_inputs();
    #1;
    check("dir_addr", 64'(awfifo_wdata), 64'h48D14E80);
    check("dir_wren", 64'(awfifo_wren), 64'd1);
    cycle();
    check("dir_inflight", 64'(inflight), 64'd1);

    // Eight back-to-back clean victims
    do_reset();
    for (int i = 0; i < 8; i++) begin offer(0); cycle(); end
    idle_inputs();
`ifdef EVICT_PUSH_STAT_EN
    #1; check("clean8", 64'(stat_clean), 64'd8);
`endif
    cycle();

    // Dirty victim while the W FIFO is almost full for five cycles
    do_reset();
    offer(1); cycle();
    idle_inputs(); wfifo_afull = 1;
    for (int i = 0; i < 5; i++) cycle();
    wfifo_afull = 0;
    cycle();
`ifdef EVICT_PUSH_STAT_EN
    #1; check("stall5", 64'(stat_stall), 64'd5);
`endif

    // Fill to the maximum; a 16th victim stalls until one completion arrives
    do_reset();
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      offer(1); cycle(); idle_inputs(); cycle();
    end
    #1; check("full15", 64'(inflight), 64'(MAX_INFLIGHT));
    offer(1); cycle(); idle_inputs();
    cycle(); cycle();
    evict_done = 1; cycle(); evict_done = 0;
    cycle();
    #1; check("refill15", 64'(inflight), 64'(MAX_INFLIGHT));

    // Push and completion in the same cycle at a count of 3; then a spurious
    // completion at a count of 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      offer(1); cycle(); idle_inputs(); cycle();
    end
    offer(1); cycle(); idle_inputs();
    evict_done = 1; cycle(); evict_done = 0;
    #1; check("push_done3", 64'(inflight), 64'd3);
    for (int i = 0; i < 3; i++) begin evict_done = 1; cycle(); end
    evict_done = 1; cycle(); evict_done = 0;
    #1; check("done_at0", 64'(inflight), 64'd0);

    // Reset asserted for one cycle while a line is pending
    offer(1); cycle(); idle_inputs(); awfifo_afull = 1; cycle();
    rst_n = 0; cycle(); rst_n = 1; awfifo_afull = 0;
    #1;
    check("rst_ready", 64'(victim_ready), 64'd1);
    check("rst_busy",  64'(evict_busy),   64'd0);
    check("rst_infl",  64'(inflight),     64'd0);
    cycle();

    // Randomized stream
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) offer(1'($urandom)); else victim_valid = 0;
      awfifo_afull = ($urandom_range(0, 4) == 0);
      wfifo_afull  = ($urandom_range(0, 4) == 0);
      evict_done   = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
